// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit single-cycle CPU: opcode encodings,
// ALU operation codes and the control sequencer state type.
package cpu_pkg;

   localparam logic [5:0] OP_NOP     = 6'b000000;
   localparam logic [2:0] OP_ALU_PFX = 3'b001;
   localparam logic [3:0] OP_LI_PFX  = 4'b0100;
   localparam logic [5:0] OP_J       = 6'b010100;
   localparam logic [5:0] OP_JZ      = 6'b010101;
   localparam logic [5:0] OP_JNZ     = 6'b010110;
   localparam logic [5:0] OP_HALT    = 6'b111111;

   // ALU operation codes are carried straight from opcode[2:0].
   localparam logic [2:0] ALU_OP0 = 3'd0;
   localparam logic [2:0] ALU_OP1 = 3'd1;
   localparam logic [2:0] ALU_OP2 = 3'd2;
   localparam logic [2:0] ALU_OP3 = 3'd3;
   localparam logic [2:0] ALU_OP4 = 3'd4;
   localparam logic [2:0] ALU_OP5 = 3'd5;
   localparam logic [2:0] ALU_OP6 = 3'd6;
   localparam logic [2:0] ALU_OP7 = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

endpackage

// File: rtl/uc_decode.sv
// Purely combinational opcode/zero-flag decoder. Produces raw datapath
// selects; the sequencer decides whether they are allowed to take effect.
module uc_decode
   import cpu_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic       z,
   output logic       s_inc,
   output logic       s_inm,
   output logic       we3,
   output logic       wez,
   output logic [2:0] op_alu,
   output logic       is_halt,
   output logic       is_illegal
);

   always_comb begin
      s_inc      = 1'b1;
      s_inm      = 1'b0;
      we3        = 1'b0;
      wez        = 1'b0;
      op_alu     = ALU_OP0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      if (opcode[5:3] == OP_ALU_PFX) begin
         op_alu = opcode[2:0];
         we3    = 1'b1;
         wez    = 1'b1;
      end else if (opcode[5:2] == OP_LI_PFX) begin
         we3   = 1'b1;
         s_inm = 1'b1;
      end else if (opcode == OP_J) begin
         s_inc = 1'b0;
      end else if (opcode == OP_JZ) begin
         s_inc = ~z;
      end else if (opcode == OP_JNZ) begin
         s_inc = z;
      end else if (opcode == OP_HALT) begin
         is_halt = 1'b1;
      end else if (opcode != OP_NOP) begin
         // unmapped encodings fall through as a NOP but are flagged
         is_illegal = 1'b1;
      end
   end

endmodule

// File: rtl/uc_ctrl.sv
// CPU control unit: opcode decode gated by a run/pause/step/halt sequencer,
// plus retired-instruction counter and sticky illegal-opcode flag.
module uc_ctrl
   import cpu_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter bit AUTORUN = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             z,
   input  logic             start,
   input  logic             stop,
   input  logic             step,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we3,
   output logic             wez,
   output logic [2:0]       op_alu,
   output logic             pc_en,
   output logic             running,
   output logic             halted,
   output logic             illegal,
   output logic             step_done,
   output logic [CNT_W-1:0] retired
);

   localparam state_t RESET_STATE = AUTORUN ? RUN : IDLE;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t     state;
   state_t     next_state;
   logic       exec;
   logic       step_exec;
   logic       dec_s_inc;
   logic       dec_s_inm;
   logic       dec_we3;
   logic       dec_wez;
   logic [2:0] dec_op_alu;
   logic       dec_is_halt;
   logic       dec_is_illegal;

   uc_decode u_decode (
      .opcode     (opcode),
      .z          (z),
      .s_inc      (dec_s_inc),
      .s_inm      (dec_s_inm),
      .we3        (dec_we3),
      .wez        (dec_wez),
      .op_alu     (dec_op_alu),
      .is_halt    (dec_is_halt),
      .is_illegal (dec_is_illegal)
   );

   // Reset is folded in so an asserted reset kills every write strobe at once.
   assign step_exec = reset & (state == IDLE) & step;
   assign exec      = (reset & (state == RUN)) | step_exec;

   assign pc_en  = exec & ~dec_is_halt;
   assign we3    = exec & dec_we3;
   assign wez    = exec & dec_wez;
   assign s_inm  = exec & dec_s_inm;
   assign s_inc  = exec ? dec_s_inc : 1'b1;
   assign op_alu = exec ? dec_op_alu : ALU_OP0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RESET_STATE;
      end else begin
         state <= next_state;
      end
   end

   // An executed HALT outranks start/stop; stop outranks start.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (exec && dec_is_halt) begin
               next_state = HALT;
            end else if (start && !stop) begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (dec_is_halt) begin
               next_state = HALT;
            end else if (stop) begin
               next_state = IDLE;
            end
         end
         HALT:    next_state = HALT;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         running   <= 1'b0;
         halted    <= 1'b0;
         illegal   <= 1'b0;
         step_done <= 1'b0;
         retired   <= '0;
      end else begin
         running   <= (next_state == RUN);
         halted    <= (next_state == HALT);
         step_done <= step_exec;
         if (exec && dec_is_illegal) begin
            illegal <= 1'b1;
         end
         if (exec && !dec_is_halt && (retired != {CNT_W{1'b1}})) begin
            retired <= retired + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_uc_ctrl.sv
// Directed bench for uc_ctrl: decode, sequencing, halt, illegal flag,
// asynchronous reset and counter saturation on a narrow second instance.
module tb_uc_ctrl;

   logic        clk;
   logic        reset;
   logic [5:0]  opcode;
   logic        z;
   logic        start;
   logic        stop;
   logic        step;
   logic        s_inc;
   logic        s_inm;
   logic        we3;
   logic        wez;
   logic [2:0]  op_alu;
   logic        pc_en;
   logic        running;
   logic        halted;
   logic        illegal;
   logic        step_done;
   logic [15:0] retired;

   logic        sat_s_inc;
   logic        sat_s_inm;
   logic        sat_we3;
   logic        sat_wez;
   logic [2:0]  sat_op_alu;
   logic        sat_pc_en;
   logic        sat_running;
   logic        sat_halted;
   logic        sat_illegal;
   logic        sat_step_done;
   logic [1:0]  sat_retired;
   logic        tie_low;

   int total = 0;
   int bad   = 0;

   uc_ctrl #(.CNT_W(16), .AUTORUN(1'b0)) dut (
      .clk       (clk),
      .reset     (reset),
      .opcode    (opcode),
      .z         (z),
      .start     (start),
      .stop      (stop),
      .step      (step),
      .s_inc     (s_inc),
      .s_inm     (s_inm),
      .we3       (we3),
      .wez       (wez),
      .op_alu    (op_alu),
      .pc_en     (pc_en),
      .running   (running),
      .halted    (halted),
      .illegal   (illegal),
      .step_done (step_done),
      .retired   (retired)
   );

   // Free-running narrow instance: always in RUN after reset.
   uc_ctrl #(.CNT_W(2), .AUTORUN(1'b1)) dut_sat (
      .clk       (clk),
      .reset     (reset),
      .opcode    (opcode),
      .z         (z),
      .start     (tie_low),
      .stop      (tie_low),
      .step      (tie_low),
      .s_inc     (sat_s_inc),
      .s_inm     (sat_s_inm),
      .we3       (sat_we3),
      .wez       (sat_wez),
      .op_alu    (sat_op_alu),
      .pc_en     (sat_pc_en),
      .running   (sat_running),
      .halted    (sat_halted),
      .illegal   (sat_illegal),
      .step_done (sat_step_done),
      .retired   (sat_retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      tie_low = 1'b0;
      reset   = 1'b0;
      start   = 1'b0;
      stop    = 1'b0;
      step    = 1'b0;
      z       = 1'b0;
      opcode  = 6'b001010;

      repeat (2) @(posedge clk);
      #1;
      check_output("rst_pc_en", {31'd0, pc_en}, 32'd0);
      check_output("rst_sat_pc_en", {31'd0, sat_pc_en}, 32'd0);
      check_output("rst_sat_we3", {31'd0, sat_we3}, 32'd0);
      check_output("rst_retired", {16'd0, retired}, 32'd0);
      check_output("rst_running", {31'd0, running}, 32'd0);
      check_output("rst_halted", {31'd0, halted}, 32'd0);
      check_output("rst_illegal", {31'd0, illegal}, 32'd0);
      check_output("rst_step_done", {31'd0, step_done}, 32'd0);
      reset = 1'b1;

      for (int i = 0; i < 10; i++) begin
         tick();
         check_output("idle_pc_en", {31'd0, pc_en}, 32'd0);
         check_output("idle_we3", {31'd0, we3}, 32'd0);
         check_output("idle_running", {31'd0, running}, 32'd0);
         check_output("idle_retired", {16'd0, retired}, 32'd0);
      end

      start = 1'b1;
      tick();
      start  = 1'b0;
      opcode = 6'b000000;
      #1;
      check_output("run_running", {31'd0, running}, 32'd1);
      check_output("nop_pc_en", {31'd0, pc_en}, 32'd1);
      check_output("nop_we3", {31'd0, we3}, 32'd0);
      tick();
      opcode = 6'b001010;
      #1;
      check_output("alu_pc_en", {31'd0, pc_en}, 32'd1);
      check_output("alu_we3", {31'd0, we3}, 32'd1);
      check_output("alu_wez", {31'd0, wez}, 32'd1);
      check_output("alu_op", {29'd0, op_alu}, 32'd2);
      check_output("alu_s_inm", {31'd0, s_inm}, 32'd0);
      tick();
      opcode = 6'b010011;
      #1;
      check_output("li_pc_en", {31'd0, pc_en}, 32'd1);
      check_output("li_we3", {31'd0, we3}, 32'd1);
      check_output("li_s_inm", {31'd0, s_inm}, 32'd1);
      check_output("li_wez", {31'd0, wez}, 32'd0);
      tick();
      check_output("retired_3", {16'd0, retired}, 32'd3);

      opcode = 6'b010101;
      z      = 1'b1;
      #1;
      check_output("jz_z1_s_inc", {31'd0, s_inc}, 32'd0);
      check_output("jz_pc_en", {31'd0, pc_en}, 32'd1);
      tick();
      z = 1'b0;
      #1;
      check_output("jz_z0_s_inc", {31'd0, s_inc}, 32'd1);
      tick();
      opcode = 6'b010110;
      #1;
      check_output("jnz_z0_s_inc", {31'd0, s_inc}, 32'd0);
      tick();
      opcode = 6'b010100;
      z      = 1'b1;
      #1;
      check_output("j_z1_s_inc", {31'd0, s_inc}, 32'd0);
      z = 1'b0;
      #1;
      check_output("j_z0_s_inc", {31'd0, s_inc}, 32'd0);
      tick();
      check_output("retired_7", {16'd0, retired}, 32'd7);

      opcode = 6'b000000;
      stop   = 1'b1;
      #1;
      check_output("stop_cycle_pc_en", {31'd0, pc_en}, 32'd1);
      tick();
      stop = 1'b0;
      check_output("stop_running", {31'd0, running}, 32'd0);
      check_output("retired_8", {16'd0, retired}, 32'd8);

      opcode = 6'b001010;
      #1;
      check_output("idle_nostep_pc_en", {31'd0, pc_en}, 32'd0);
      step = 1'b1;
      #1;
      check_output("step_pc_en", {31'd0, pc_en}, 32'd1);
      check_output("step_we3", {31'd0, we3}, 32'd1);
      tick();
      step = 1'b0;
      #1;
      check_output("step_done_1", {31'd0, step_done}, 32'd1);
      check_output("step_retired", {16'd0, retired}, 32'd9);
      check_output("after_step_pc_en", {31'd0, pc_en}, 32'd0);
      check_output("step_running", {31'd0, running}, 32'd0);
      tick();
      check_output("step_done_0", {31'd0, step_done}, 32'd0);
      check_output("step_retired_hold", {16'd0, retired}, 32'd9);

      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      check_output("startstop_running", {31'd0, running}, 32'd0);
      tick();
      check_output("startstop_running2", {31'd0, running}, 32'd0);
      check_output("startstop_retired", {16'd0, retired}, 32'd9);

      start = 1'b1;
      tick();
      start  = 1'b0;
      opcode = 6'b100000;
      #1;
      check_output("ill_running", {31'd0, running}, 32'd1);
      check_output("ill_pc_en", {31'd0, pc_en}, 32'd1);
      check_output("ill_we3", {31'd0, we3}, 32'd0);
      check_output("ill_wez", {31'd0, wez}, 32'd0);
      check_output("ill_s_inc", {31'd0, s_inc}, 32'd1);
      tick();
      check_output("illegal_set", {31'd0, illegal}, 32'd1);
      opcode = 6'b000000;
      tick();
      check_output("illegal_sticky", {31'd0, illegal}, 32'd1);
      check_output("retired_11", {16'd0, retired}, 32'd11);

      opcode = 6'b111111;
      #1;
      check_output("halt_pc_en", {31'd0, pc_en}, 32'd0);
      check_output("halt_we3", {31'd0, we3}, 32'd0);
      tick();
      check_output("halted_1", {31'd0, halted}, 32'd1);
      check_output("halt_running", {31'd0, running}, 32'd0);
      check_output("halt_retired", {16'd0, retired}, 32'd11);
      opcode = 6'b001010;
      start  = 1'b1;
      #1;
      check_output("halt_start_pc_en", {31'd0, pc_en}, 32'd0);
      tick();
      start = 1'b0;
      step  = 1'b1;
      #1;
      check_output("halt_step_pc_en", {31'd0, pc_en}, 32'd0);
      check_output("halt_step_we3", {31'd0, we3}, 32'd0);
      tick();
      step = 1'b0;
      check_output("halt_retired_hold", {16'd0, retired}, 32'd11);
      check_output("halt_hold", {31'd0, halted}, 32'd1);
      check_output("halt_step_done", {31'd0, step_done}, 32'd0);
      check_output("halt_illegal", {31'd0, illegal}, 32'd1);

      #2;
      reset = 1'b0;
      #1;
      check_output("async_halted", {31'd0, halted}, 32'd0);
      check_output("async_illegal", {31'd0, illegal}, 32'd0);
      check_output("async_retired", {16'd0, retired}, 32'd0);
      tick();
      reset = 1'b1;

      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      check_output("rerun_pc_en", {31'd0, pc_en}, 32'd1);
      check_output("rerun_we3", {31'd0, we3}, 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check_output("midrst_pc_en", {31'd0, pc_en}, 32'd0);
      check_output("midrst_we3", {31'd0, we3}, 32'd0);
      check_output("midrst_wez", {31'd0, wez}, 32'd0);
      check_output("midrst_op_alu", {29'd0, op_alu}, 32'd0);
      check_output("midrst_s_inc", {31'd0, s_inc}, 32'd1);
      check_output("midrst_running", {31'd0, running}, 32'd0);
      check_output("midrst_retired", {16'd0, retired}, 32'd0);

      opcode = 6'b000000;
      tick();
      reset = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check_output("sat_retired", {30'd0, sat_retired}, (i < 3) ? i : 32'd3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uc_ctrl.md
Name: uc_ctrl

Overview:
- Control unit for the single-cycle 8-bit CPU datapath (10-bit PC, 16-bit instructions, opcode = instr[15:10], zero flag z).
- Decodes the opcode and z into the datapath selects: s_inc, s_inm, we3, wez, op_alu.
- Adds a run/pause/step/halt sequencer. The datapath PC and zero flip-flop advance only when pc_en=1.
- Keeps a retired-instruction counter and an illegal-opcode flag for debug.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- AUTORUN, 0, 1 = leave reset directly in RUN; 0 = leave reset in IDLE.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[15:10] from the datapath.
- z  in  1  registered zero flag from the datapath.
- start  in  1  pulse: IDLE -> RUN.
- stop  in  1  pulse: RUN -> IDLE.
- step  in  1  pulse: execute exactly one instruction while IDLE.
- s_inc  out  1  1 = PC+1, 0 = PC <- instr[9:0].
- s_inm  out  1  1 = write immediate instr[11:4], 0 = write ALU result.
- we3  out  1  register file write enable.
- wez  out  1  zero flag load enable.
- op_alu  out  3  ALU operation.
- pc_en  out  1  PC/zero-flag update enable (execute strobe).
- running  out  1  registered, state==RUN.
- halted  out  1  registered, state==HALT.
- illegal  out  1  sticky, set when an unmapped opcode is executed.
- step_done  out  1  one-cycle pulse after a step executes.
- retired  out  CNT_W  count of executed instructions.

Behaviour:
- States: IDLE, RUN, HALT.
- Reset (reset=0, async): state=IDLE, or RUN if AUTORUN=1. running/halted/illegal/step_done=0, retired=0.
- exec = (state==RUN) | (state==IDLE & step). Combinational, same cycle.
- Control outputs are combinational from exec, opcode and z.
- When exec=0, or while reset is asserted: pc_en=0, we3=0, wez=0, s_inc=1, s_inm=0, op_alu=0.
- Opcode map when exec=1:
  - 6'b000000 NOP: pc_en=1, s_inc=1.
  - 6'b001xxx ALU: op_alu=opcode[2:0], we3=1, wez=1, s_inm=0, s_inc=1, pc_en=1.
  - 6'b0100xx LI: the xx bits are immediate bits [7:6]. we3=1, s_inm=1, wez=0, s_inc=1, pc_en=1.
  - 6'b010100 J: s_inc=0, pc_en=1.
  - 6'b010101 JZ: s_inc=~z, pc_en=1.
  - 6'b010110 JNZ: s_inc=z, pc_en=1.
  - 6'b111111 HALT: pc_en=0, no writes. Next state HALT; PC stays on the HALT word.
  - Any other opcode: executes as NOP and sets illegal on that edge.
- Transitions:
  - IDLE + start -> RUN.
  - RUN + stop -> IDLE. The instruction in the stop cycle still executes, because exec depends only on state.
  - start and stop in the same cycle: stop wins. From IDLE, stay IDLE; from RUN, go IDLE.
  - step while RUN or HALT: ignored.
  - step in IDLE: one instruction executes that cycle. step_done=1 the next cycle. State stays IDLE, unless the instruction is HALT -> HALT.
  - step held high for N cycles in IDLE executes N instructions (level-sensitive). Benches drive single-cycle pulses.
  - HALT is terminal. start, stop and step are ignored; only reset leaves it.
- retired: +1 on every edge with exec=1 and opcode != HALT, including illegal NOPs. Saturates at all-ones; no wrap.
- illegal: sticky until reset.
- Latency: control decode is 0 cycles; the status outputs follow 1 cycle after the triggering edge.
- Reset asserted mid-instruction: pc_en drops immediately (combinational), so no partial write is committed.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants: OP_NOP, OP_ALU_PFX, OP_LI_PFX, OP_J, OP_JZ, OP_JNZ, OP_HALT;
  - ALU op codes;
  - the state enum {IDLE, RUN, HALT}.
- One sub-module, uc_decode: purely combinational opcode+z -> selects plus is_halt/is_illegal.
- uc_ctrl holds the FSM, counters and gating.

Test Plan:
- Reset with AUTORUN=0, opcode=6'b001010, no start -> pc_en=0, we3=0, running=0, retired=0 for 10 cycles.
- start pulse, stream NOP, ALU(op 3'b010), LI(6'b010011) -> pc_en=1 each cycle. ALU cycle: we3=1, wez=1, op_alu=3'b010. LI cycle: s_inm=1, wez=0. retired=3.
- JZ with z=1 then z=0 -> s_inc=0 then s_inc=1. JNZ with z=0 -> s_inc=0. J -> s_inc=0 regardless of z.
- IDLE, one-cycle step on ALU -> exactly one pc_en=1 cycle, step_done=1 next cycle, retired +1. start+stop in the same cycle -> running stays 0.
- RUN, opcode 6'b111111 -> pc_en=0 that cycle, halted=1 next cycle. Later start/step pulses do not raise pc_en; retired unchanged.
- Opcode 6'b100000 in RUN -> acts as NOP (pc_en=1, we3=0), illegal=1 and stays 1. Async reset mid-run -> all outputs to reset values without waiting for a clk edge. CNT_W=2 with 5 NOPs -> retired saturates at 3.
